// File: rtl/iq_binner.sv
// 2-D IQ histogram binner: maps each integrated (I,Q) shot to a bin by iterative
// subtraction and increments a saturating count in on-chip histogram RAM.
module iq_binner #(
    parameter int unsigned MAX_BINS = 32,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk100,
    input  logic             reset_n,
    input  logic             iq_valid,
    input  logic [31:0]      i_val,
    input  logic [31:0]      q_val,
    input  logic [15:0]      x_bin_width,
    input  logic [15:0]      y_bin_width,
    input  logic [4:0]       x_bin_num,
    input  logic [4:0]       y_bin_num,
    input  logic [15:0]      x_bin_min,
    input  logic [15:0]      y_bin_min,
    input  logic             clear,
    input  logic             rd_req,
    input  logic [9:0]       rd_addr,
    output logic             rd_valid,
    output logic [CNT_W-1:0] rd_data,
    output logic             busy,
    output logic [15:0]      shot_count,
    output logic [15:0]      oor_count,
    output logic [15:0]      drop_count
);

    localparam int unsigned Depth = MAX_BINS * MAX_BINS;

    typedef enum logic [2:0] {StIdle, StClear, StDivide, StRead, StUpdate} state_e;

    // Remainder is 33 bits so that any 32-bit sample minus a 16-bit edge fits.
    typedef struct packed {
        logic [32:0] r;
        logic [4:0]  idx;
        logic        done;
        logic        oor;
    } axis_t;

    function automatic axis_t axis_step(axis_t a, logic [15:0] w, logic [4:0] n);
        axis_t s;
        s = a;
        if (!a.done) begin
            if (a.r[32] || w == 16'd0 || n == 5'd0) begin
                s.done = 1'b1;
                s.oor  = 1'b1;
            end else if (a.r < {17'd0, w}) begin
                s.done = 1'b1;
            end else if (a.idx == n - 5'd1) begin
                s.done = 1'b1;
                s.oor  = 1'b1;
            end else begin
                s.r   = a.r - {17'd0, w};
                s.idx = a.idx + 5'd1;
            end
        end
        return s;
    endfunction

    function automatic logic [15:0] sat_inc(logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_e      state_q, state_d;
    axis_t       x_q, x_d, y_q, y_d;
    logic [15:0] xw_q, xw_d, yw_q, yw_d;
    logic [4:0]  xn_q, xn_d, yn_q, yn_d;
    logic [9:0]  clr_addr_q, clr_addr_d;
    logic [15:0] shot_q, shot_d, oor_q, oor_d, drop_q, drop_d;
    logic        rd_valid_q, rd_valid_d;

    logic             mem_we, mem_re;
    logic [9:0]       mem_waddr, mem_raddr;
    logic [CNT_W-1:0] mem_wdata, mem_q;
    logic [CNT_W-1:0] hist_mem [Depth];

    always_ff @(posedge clk100) begin
        if (mem_we) hist_mem[mem_waddr] <= mem_wdata;
        if (mem_re) mem_q <= hist_mem[mem_raddr];
    end

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        xw_d       = xw_q;
        yw_d       = yw_q;
        xn_d       = xn_q;
        yn_d       = yn_q;
        clr_addr_d = clr_addr_q;
        shot_d     = shot_q;
        oor_d      = oor_q;
        drop_d     = drop_q;
        rd_valid_d = 1'b0;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        mem_waddr  = clr_addr_q;
        mem_raddr  = rd_addr;
        mem_wdata  = '0;

        if (state_q == StClear) mem_we = 1'b1;

        // Clear wins over everything in every state and aborts any shot in flight.
        if (clear) begin
            state_d    = StClear;
            clr_addr_d = '0;
            shot_d     = '0;
            oor_d      = '0;
            drop_d     = '0;
        end else begin
            if (state_q != StIdle && iq_valid) drop_d = sat_inc(drop_q);
            unique case (state_q)
                StIdle: begin
                    if (iq_valid) begin
                        xw_d    = x_bin_width;
                        yw_d    = y_bin_width;
                        xn_d    = x_bin_num;
                        yn_d    = y_bin_num;
                        x_d     = '{r: {i_val[31], i_val} - {{17{x_bin_min[15]}}, x_bin_min},
                                    idx: '0, done: 1'b0, oor: 1'b0};
                        y_d     = '{r: {q_val[31], q_val} - {{17{y_bin_min[15]}}, y_bin_min},
                                    idx: '0, done: 1'b0, oor: 1'b0};
                        state_d = StDivide;
                    end else if (rd_req) begin
                        mem_re     = 1'b1;
                        rd_valid_d = 1'b1;
                    end
                end
                StClear: begin
                    if (clr_addr_q == 10'(Depth - 1)) state_d = StIdle;
                    else clr_addr_d = clr_addr_q + 10'd1;
                end
                StDivide: begin
                    x_d = axis_step(x_q, xw_q, xn_q);
                    y_d = axis_step(y_q, yw_q, yn_q);
                    if (x_d.done && y_d.done) begin
                        if (x_d.oor || y_d.oor) begin
                            oor_d   = sat_inc(oor_q);
                            state_d = StIdle;
                        end else begin
                            state_d = StRead;
                        end
                    end
                end
                StRead: begin
                    mem_re    = 1'b1;
                    mem_raddr = {y_q.idx, x_q.idx};
                    state_d   = StUpdate;
                end
                StUpdate: begin
                    mem_we    = 1'b1;
                    mem_waddr = {y_q.idx, x_q.idx};
                    mem_wdata = sat_inc(mem_q);
                    shot_d    = sat_inc(shot_q);
                    state_d   = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk100 or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            x_q        <= '0;
            y_q        <= '0;
            xw_q       <= '0;
            yw_q       <= '0;
            xn_q       <= '0;
            yn_q       <= '0;
            clr_addr_q <= '0;
            shot_q     <= '0;
            oor_q      <= '0;
            drop_q     <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            xw_q       <= xw_d;
            yw_q       <= yw_d;
            xn_q       <= xn_d;
            yn_q       <= yn_d;
            clr_addr_q <= clr_addr_d;
            shot_q     <= shot_d;
            oor_q      <= oor_d;
            drop_q     <= drop_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_valid   = rd_valid_q;
    assign rd_data    = rd_valid_q ? mem_q : '0;
    assign busy       = (state_q != StIdle);
    assign shot_count = shot_q;
    assign oor_count  = oor_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_iq_binner.sv
// Scoreboard bench for iq_binner: a reference binning model predicts RAM contents
// and counters; readout results are queued on request and compared on rd_valid.
module tb_iq_binner;

    logic        clk100 = 1'b0;
    logic        reset_n;
    logic        iq_valid, clear, rd_req;
    logic [31:0] i_val, q_val;
    logic [15:0] x_bin_width, y_bin_width, x_bin_min, y_bin_min;
    logic [4:0]  x_bin_num, y_bin_num;
    logic [9:0]  rd_addr;
    logic        rd_valid, busy;
    logic [15:0] rd_data, shot_count, oor_count, drop_count;

    iq_binner dut (
        .clk100      (clk100),
        .reset_n     (reset_n),
        .iq_valid    (iq_valid),
        .i_val       (i_val),
        .q_val       (q_val),
        .x_bin_width (x_bin_width),
        .y_bin_width (y_bin_width),
        .x_bin_num   (x_bin_num),
        .y_bin_num   (y_bin_num),
        .x_bin_min   (x_bin_min),
        .y_bin_min   (y_bin_min),
        .clear       (clear),
        .rd_req      (rd_req),
        .rd_addr     (rd_addr),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .busy        (busy),
        .shot_count  (shot_count),
        .oor_count   (oor_count),
        .drop_count  (drop_count)
    );

    always #5 clk100 = ~clk100;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [15:0] hist_m [1024];
    logic [15:0] shot_m, oor_m, drop_m;
    int          xw, yw, xn, yn, xmin, ymin;
    logic [15:0] rq [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] sat16(logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic int bin_of(int v, int mn, int w, int n);
        longint r;
        r = longint'(v) - longint'(mn);
        if (w == 0 || n == 0 || r < 0) return -1;
        if (r / longint'(w) >= longint'(n)) return -1;
        return int'(r / longint'(w));
    endfunction

    always @(negedge clk100) begin
        if (rd_valid) begin
            if (rq.size() == 0) check("rd_unexpected", {31'd0, rd_valid}, 32'd0);
            else check("rd_data", {16'd0, rd_data}, {16'd0, rq.pop_front()});
        end
    end

    task automatic apply_cfg();
        x_bin_width = 16'(xw);
        y_bin_width = 16'(yw);
        x_bin_num   = 5'(xn);
        y_bin_num   = 5'(yn);
        x_bin_min   = 16'(xmin);
        y_bin_min   = 16'(ymin);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 2000) begin
            @(negedge clk100);
            n++;
        end
        if (busy) check("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_shot"}, {16'd0, shot_count}, {16'd0, shot_m});
        check({tag, "_oor"},  {16'd0, oor_count},  {16'd0, oor_m});
        check({tag, "_drop"}, {16'd0, drop_count}, {16'd0, drop_m});
    endtask

    task automatic model_shot(input int iv, input int qv, output int bx, output int by);
        bx = bin_of(iv, xmin, xw, xn);
        by = bin_of(qv, ymin, yw, yn);
        if (bx < 0 || by < 0) oor_m = sat16(oor_m);
        else begin
            hist_m[by * 32 + bx] = sat16(hist_m[by * 32 + bx]);
            shot_m = sat16(shot_m);
        end
    endtask

    task automatic shot(input int iv, input int qv, output int cyc, output int exp_cyc);
        int bx, by;
        wait_idle();
        @(negedge clk100);
        i_val = iv;
        q_val = qv;
        iq_valid = 1'b1;
        model_shot(iv, qv, bx, by);
        exp_cyc = (bx < 0 || by < 0) ? -1 : ((bx > by) ? bx : by) + 3;
        @(negedge clk100);
        iq_valid = 1'b0;
        cyc = 0;
        while (busy && cyc < 100) begin
            cyc++;
            @(negedge clk100);
        end
    endtask

    task automatic do_read(input int addr);
        wait_idle();
        @(negedge clk100);
        rd_req  = 1'b1;
        rd_addr = 10'(addr);
        rq.push_back(hist_m[addr]);
        @(negedge clk100);
        rd_req = 1'b0;
    endtask

    task automatic model_clear();
        for (int k = 0; k < 1024; k++) hist_m[k] = 16'd0;
        shot_m = 16'd0;
        oor_m  = 16'd0;
        drop_m = 16'd0;
    endtask

    task automatic do_clear();
        wait_idle();
        @(negedge clk100);
        clear = 1'b1;
        @(negedge clk100);
        clear = 1'b0;
        model_clear();
        wait_idle();
    endtask

    initial begin
        int cyc, exp_cyc;
        reset_n  = 1'b0;
        iq_valid = 1'b0;
        clear    = 1'b0;
        rd_req   = 1'b0;
        rd_addr  = '0;
        i_val    = '0;
        q_val    = '0;
        xw = 100; yw = 100; xn = 10; yn = 10; xmin = 0; ymin = 0;
        apply_cfg();
        shot_m = 16'd0; oor_m = 16'd0; drop_m = 16'd0;
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        check("rst_rd_data", {16'd0, rd_data}, 32'd0);
        check_counts("rst");
        repeat (3) @(negedge clk100);
        reset_n = 1'b1;

        do_clear();
        check_counts("clr0");

        // Basic in-range shot: x=2, y=0 -> addr 2
        shot(250, 50, cyc, exp_cyc);
        check("len_250_50", 32'(cyc), 32'(exp_cyc));
        check_counts("s1");
        do_read(2);

        // Out of range below, at upper edge, and just under the edge
        shot(-1, 50, cyc, exp_cyc);
        check_counts("neg");
        do_read(2);
        shot(1000, 50, cyc, exp_cyc);
        check_counts("edge");
        shot(999, 50, cyc, exp_cyc);
        check("len_999", 32'(cyc), 32'(exp_cyc));
        check_counts("999");
        do_read(9);

        // Negative lower edge; q lands exactly on the y=1 boundary
        xmin = -500; ymin = -500;
        apply_cfg();
        shot(-500, -400, cyc, exp_cyc);
        check_counts("negmin");
        do_read(32);
        do_read(0);

        // Three identical shots into x=3, y=1
        xmin = 0; ymin = 0;
        apply_cfg();
        for (int k = 0; k < 3; k++) begin
            shot(350, 120, cyc, exp_cyc);
            check("len_rep", 32'(cyc), 32'(exp_cyc));
        end
        check_counts("rep");
        do_read(35);

        // Zero width and zero bin count are always out of range
        xw = 0;
        apply_cfg();
        shot(50, 50, cyc, exp_cyc);
        xw = 100; yn = 0;
        apply_cfg();
        shot(50, 50, cyc, exp_cyc);
        yn = 10;
        apply_cfg();
        check_counts("degen");
        do_read(0);

        // Second iq_valid one cycle after accept is dropped
        wait_idle();
        @(negedge clk100);
        i_val = 150; q_val = 250; iq_valid = 1'b1;
        model_shot(150, 250, cyc, exp_cyc);
        @(negedge clk100);
        i_val = 550; q_val = 50;
        drop_m = sat16(drop_m);
        @(negedge clk100);
        iq_valid = 1'b0;
        wait_idle();
        check_counts("drop");
        do_read(65);
        do_read(5);

        // rd_req while busy must be ignored
        wait_idle();
        @(negedge clk100);
        i_val = 2500; q_val = 50; iq_valid = 1'b1;
        model_shot(2500, 50, cyc, exp_cyc);
        @(negedge clk100);
        iq_valid = 1'b0; rd_req = 1'b1; rd_addr = 10'd65;
        @(negedge clk100);
        rd_req = 1'b0;
        check("rd_while_busy", {31'd0, rd_valid}, 32'd0);
        wait_idle();
        check_counts("rdbusy");

        // Count saturation: preload bin 0 near full, then two shots
        wait_idle();
        @(negedge clk100);
        dut.hist_mem[0] = 16'hFFFE;
        hist_m[0] = 16'hFFFE;
        shot(10, 10, cyc, exp_cyc);
        shot(10, 10, cyc, exp_cyc);
        do_read(0);
        check_counts("sat");

        // clear and iq_valid together: clear wins, shot neither binned nor dropped
        wait_idle();
        @(negedge clk100);
        clear = 1'b1; iq_valid = 1'b1; i_val = 250; q_val = 50;
        @(negedge clk100);
        clear = 1'b0; iq_valid = 1'b0;
        check("clear_busy", {31'd0, busy}, 32'd1);
        model_clear();
        wait_idle();
        check_counts("clriq");
        for (int a = 0; a < 1024; a++) do_read(a);
        repeat (3) @(negedge clk100);

        // Async reset during a long DIVIDE
        xn = 31;
        apply_cfg();
        @(negedge clk100);
        i_val = 2900; q_val = 50; iq_valid = 1'b1;
        @(negedge clk100);
        iq_valid = 1'b0;
        repeat (4) @(negedge clk100);
        check("div_busy", {31'd0, busy}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_shot", {16'd0, shot_count}, 32'd0);
        @(negedge clk100);
        reset_n = 1'b1;
        repeat (2) @(negedge clk100);
        check("rst_mid_idle", {31'd0, busy}, 32'd0);

        check("rq_empty", 32'(rq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
